// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: start/busy/done sequencer for the regfile/ALU/input-buffer datapath.
// Loads two seeds into R0/R1 through the immediate path. It then issues COUNT
// chained ALU ops R[k] = R[k-1] op R[k-2] for k = 2..COUNT+1, with hold/stall.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start, all outputs 0, ALUOp = NOP
// LOAD0 | write latched seed0 into R0 via immediate buffer path
// LOAD1 | write latched seed1 into R1 via immediate buffer path
// RUN   | ALU step k = step_q: R[k] = R[k-1] op R[k-2] via ALU path
// DONE  | single-cycle done pulse, then back to IDLE
module fib_seq_ctrl #(
  parameter int DATA_W    = 16,
  parameter int RADDR_W   = 4,
  parameter int MAX_STEPS = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  seed0,
  input  logic [DATA_W-1:0]  seed1,
  input  logic [3:0]         count,
  input  logic [7:0]         op_sel,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  initialR,
  output logic [RADDR_W-1:0] regWrite,
  output logic [RADDR_W-1:0] regRead1,
  output logic [RADDR_W-1:0] regRead2,
  output logic [7:0]         ALUOp,
  output logic [3:0]         buffCtrl,
  output logic               regWriteEn
);

  localparam logic [7:0] ALU_NOP = 8'h00;
  localparam logic [3:0] BUF_OFF = 4'b0000;
  localparam logic [3:0] BUF_IMM = 4'b0001;
  localparam logic [3:0] BUF_ALU = 4'b1110;
  localparam logic [3:0] MAX_CNT = 4'(MAX_STEPS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD0 = 3'd1,
    ST_LOAD1 = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [RADDR_W-1:0]   step_q, step_d;
  logic [DATA_W-1:0]    seed0_q, seed0_d;
  logic [DATA_W-1:0]    seed1_q, seed1_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           op_q, op_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DATA_W-1:0]    initialR_q, initialR_d;
  logic [RADDR_W-1:0]   regWrite_q, regWrite_d;
  logic [RADDR_W-1:0]   regRead1_q, regRead1_d;
  logic [RADDR_W-1:0]   regRead2_q, regRead2_d;
  logic [7:0]           ALUOp_q, ALUOp_d;
  logic [3:0]           buffCtrl_q, buffCtrl_d;
  logic                 regWriteEn_q, regWriteEn_d;

  logic [3:0]           count_clamped;
  logic [RADDR_W-1:0]   last_step;
  logic                 in_busy_state;
  logic                 stall;
  logic                 advance;

  // The clamp keeps the last destination at R15 so the step counter can never
  // wrap back onto the seed registers.
  assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;
  assign last_step     = RADDR_W'(cnt_q) + RADDR_W'(1);

  assign in_busy_state = (state_q == ST_LOAD0) || (state_q == ST_LOAD1) ||
                         (state_q == ST_RUN);
  assign stall         = in_busy_state && hold;
  // A step presented with regWriteEn low was frozen by hold and has not been
  // written yet, so it is re-issued before the sequence moves on.
  assign advance       = in_busy_state && !hold && regWriteEn_q;

  // Next state, step counter and latched sequence parameters.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    seed0_d = seed0_q;
    seed1_d = seed1_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed0_d = seed0;
          seed1_d = seed1;
          cnt_d   = count_clamped;
          op_d    = op_sel;
          state_d = ST_LOAD0;
          step_d  = '0;
        end
      end
      ST_LOAD0: begin
        if (advance) begin
          state_d = ST_LOAD1;
          step_d  = RADDR_W'(1);
        end
      end
      ST_LOAD1: begin
        if (advance) begin
          if (cnt_q != 4'd0) begin
            state_d = ST_RUN;
            step_d  = RADDR_W'(2);
          end else begin
            state_d = ST_DONE;
            step_d  = '0;
          end
        end
      end
      ST_RUN: begin
        if (advance) begin
          if (step_q == last_step) begin
            state_d = ST_DONE;
            step_d  = '0;
          end else begin
            step_d  = step_q + RADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Output decode for the state being entered, so outputs change on the entry edge.
  always_comb begin
    busy_d       = 1'b0;
    done_d       = 1'b0;
    initialR_d   = '0;
    regWrite_d   = '0;
    regRead1_d   = '0;
    regRead2_d   = '0;
    ALUOp_d      = ALU_NOP;
    buffCtrl_d   = BUF_OFF;
    regWriteEn_d = 1'b0;
    case (state_d)
      ST_LOAD0: begin
        busy_d       = 1'b1;
        initialR_d   = seed0_d;
        buffCtrl_d   = BUF_IMM;
        regWriteEn_d = !stall;
      end
      ST_LOAD1: begin
        busy_d       = 1'b1;
        initialR_d   = seed1_d;
        regWrite_d   = RADDR_W'(1);
        buffCtrl_d   = BUF_IMM;
        regWriteEn_d = !stall;
      end
      ST_RUN: begin
        busy_d       = 1'b1;
        regWrite_d   = step_d;
        regRead1_d   = step_d - RADDR_W'(1);
        regRead2_d   = step_d - RADDR_W'(2);
        ALUOp_d      = op_d;
        buffCtrl_d   = BUF_ALU;
        regWriteEn_d = !stall;
      end
      ST_DONE: begin
        done_d       = 1'b1;
      end
      default: begin
        busy_d       = 1'b0;
      end
    endcase
  end

  // State, parameters and registered outputs; reset aborts any sequence at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      seed0_q      <= '0;
      seed1_q      <= '0;
      cnt_q        <= '0;
      op_q         <= ALU_NOP;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      initialR_q   <= '0;
      regWrite_q   <= '0;
      regRead1_q   <= '0;
      regRead2_q   <= '0;
      ALUOp_q      <= ALU_NOP;
      buffCtrl_q   <= BUF_OFF;
      regWriteEn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      seed0_q      <= seed0_d;
      seed1_q      <= seed1_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      initialR_q   <= initialR_d;
      regWrite_q   <= regWrite_d;
      regRead1_q   <= regRead1_d;
      regRead2_q   <= regRead2_d;
      ALUOp_q      <= ALUOp_d;
      buffCtrl_q   <= buffCtrl_d;
      regWriteEn_q <= regWriteEn_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign initialR   = initialR_q;
  assign regWrite   = regWrite_q;
  assign regRead1   = regRead1_q;
  assign regRead2   = regRead2_q;
  assign ALUOp      = ALUOp_q;
  assign buffCtrl   = buffCtrl_q;
  assign regWriteEn = regWriteEn_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: drives fib_seq_ctrl with directed and randomized sequences.
// It compares every cycle against an issue-list model and attaches a small
// regfile/ALU so that the final register contents can be checked against
// plain arithmetic.
module tb_fib_seq_ctrl;

  localparam logic [7:0] NOP    = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_XOR = 8'h03;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed0 = '0;
  logic [15:0] seed1 = '0;
  logic [3:0]  count = '0;
  logic [7:0]  op_sel = '0;
  logic        hold = 1'b0;
  logic        busy, done, regWriteEn;
  logic [15:0] initialR;
  logic [3:0]  regWrite, regRead1, regRead2, buffCtrl;
  logic [7:0]  ALUOp;

  int checks = 0;
  int errors = 0;

  logic [15:0] rf [16];
  int          wr_total;
  int          alu_wr_low;

  logic [42:0] obs_v;
  assign obs_v = {busy, done, initialR, regWrite, regRead1, regRead2, ALUOp, buffCtrl, regWriteEn};

  fib_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .seed0(seed0), .seed1(seed1),
    .count(count), .op_sel(op_sel), .hold(hold), .busy(busy), .done(done),
    .initialR(initialR), .regWrite(regWrite), .regRead1(regRead1),
    .regRead2(regRead2), .ALUOp(ALUOp), .buffCtrl(buffCtrl), .regWriteEn(regWriteEn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b,
                                      input logic [7:0] op);
    case (op)
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [42:0] pk(input logic b, input logic d, input logic [15:0] ir,
                                     input logic [3:0] wa, input logic [3:0] r1,
                                     input logic [3:0] r2, input logic [7:0] op,
                                     input logic [3:0] bf);
    return {b, d, ir, wa, r1, r2, op, bf, 1'b0};
  endfunction

  // One clock: the bench regfile performs the write the DUT presents at this edge.
  task automatic tick();
    if (regWriteEn === 1'b1) begin
      wr_total++;
      if (buffCtrl == 4'b1110 && regWrite < 4'd2) alu_wr_low++;
      if (buffCtrl == 4'b0001) rf[regWrite] = initialR;
      else if (buffCtrl == 4'b1110) rf[regWrite] = alu(rf[regRead1], rf[regRead2], ALUOp);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one sequence from IDLE. hk/hl: fixed hold of hl cycles at RUN k=hk.
  // rk: assert reset while RUN k=rk is presented. spam: re-pulse start while busy.
  task automatic run_seq(input string name, input logic [15:0] s0, input logic [15:0] s1,
                         input logic [3:0] cnt, input logic [7:0] op, input int hold_pct,
                         input int hk, input int hl, input int rk, input bit spam);
    logic [42:0] exp_q[$];
    logic [42:0] expv;
    logic [15:0] ref_rf [16];
    int c, cur, held, cyc, dones, done_cyc, wt;
    bit en, h, busy_item, is_run;
    logic [3:0] cur_k;

    c = (cnt > 4'd14) ? 14 : int'(cnt);
    for (int i = 0; i < 16; i++) rf[i] = 16'hDEAD;
    wr_total = 0;
    alu_wr_low = 0;
    exp_q = {};
    exp_q.push_back(pk(1'b1, 1'b0, s0, 4'd0, 4'd0, 4'd0, NOP, 4'b0001));
    exp_q.push_back(pk(1'b1, 1'b0, s1, 4'd1, 4'd0, 4'd0, NOP, 4'b0001));
    for (int k = 2; k <= c + 1; k++)
      exp_q.push_back(pk(1'b1, 1'b0, 16'd0, 4'(k), 4'(k - 1), 4'(k - 2), op, 4'b1110));
    exp_q.push_back(pk(1'b0, 1'b1, 16'd0, 4'd0, 4'd0, 4'd0, NOP, 4'b0000));
    exp_q.push_back(pk(1'b0, 1'b0, 16'd0, 4'd0, 4'd0, 4'd0, NOP, 4'b0000));

    seed0 = s0; seed1 = s1; count = cnt; op_sel = op; start = 1'b1;
    hold = 1'($urandom_range(1));
    tick();
    start = 1'b0;
    cur = 0; en = 1'b1; held = 0; cyc = 0; dones = 0; done_cyc = -1;
    chk({name, "_accept"}, 64'(obs_v), 64'(exp_q[0] | 43'd1));

    while (cur < exp_q.size() - 1 && cyc < 300) begin
      seed0 = 16'($urandom); seed1 = 16'($urandom);
      count = 4'($urandom); op_sel = 8'($urandom);
      start = spam ? 1'($urandom_range(1)) : 1'b0;
      busy_item = exp_q[cur][42];
      is_run    = (exp_q[cur][4:1] == 4'b1110);
      cur_k     = exp_q[cur][24:21];

      if (rk > 0 && is_run && cur_k == 4'(rk) && en) begin
        start = 1'b0; hold = 1'b0;
        reset = 1'b0;
        #1;
        chk({name, "_rst_async"}, 64'(obs_v), 64'd0);
        wt = wr_total;
        tick();
        tick();
        chk({name, "_rst_hold"}, 64'(obs_v), 64'd0);
        chk({name, "_rst_nowrite"}, 64'(wr_total), 64'(wt));
        chk({name, "_rst_nodone"}, 64'(dones), 64'd0);
        reset = 1'b1;
        tick();
        chk({name, "_rst_idle"}, 64'(obs_v), 64'd0);
        return;
      end

      h = 1'b0;
      if (hk > 0 && is_run && cur_k == 4'(hk) && held < hl) begin
        h = 1'b1;
        held++;
      end else if (hold_pct > 0) begin
        h = ($urandom_range(99) < hold_pct);
      end
      hold = h;
      tick();
      cyc++;

      if (busy_item && h) en = 1'b0;
      else if (busy_item && !en) en = 1'b1;
      else begin
        cur++;
        en = exp_q[cur][42];
      end
      expv = exp_q[cur] | 43'(en);
      if (done === 1'b1) begin
        dones++;
        done_cyc = cyc;
      end
      chk($sformatf("%s_c%0d", name, cyc), 64'(obs_v), 64'(expv));
    end
    hold = 1'b0;
    start = 1'b0;

    chk({name, "_seq_end"}, 64'(cur), 64'(exp_q.size() - 1));
    chk({name, "_done_pulses"}, 64'(dones), 64'd1);
    if (hk == 0 && hold_pct == 0)
      chk({name, "_done_lat"}, 64'(done_cyc), 64'(c + 2));
    chk({name, "_alu_wr_r0r1"}, 64'(alu_wr_low), 64'd0);

    for (int i = 0; i < 16; i++) ref_rf[i] = 16'hDEAD;
    ref_rf[0] = s0;
    ref_rf[1] = s1;
    for (int k = 2; k <= c + 1; k++) ref_rf[k] = alu(ref_rf[k - 1], ref_rf[k - 2], op);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_R%0d", name, i), 64'(rf[i]), 64'(ref_rf[i]));
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("reset_outputs", 64'(obs_v), 64'd0);
    repeat (2) @(negedge clk);
    chk("reset_held", 64'(obs_v), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    hold = 1'b1;
    @(negedge clk);
    chk("idle_no_start", 64'(obs_v), 64'd0);
    hold = 1'b0;

    run_seq("fib13", 16'd0, 16'd1, 4'd13, OP_ADD, 0, 0, 0, 0, 1'b0);
    run_seq("fib14", 16'd0, 16'd1, 4'd14, OP_ADD, 0, 0, 0, 0, 1'b0);
    chk("fib14_r15_610", 64'(rf[15]), 64'd610);
    run_seq("cnt0", 16'd7, 16'd9, 4'd0, OP_ADD, 0, 0, 0, 0, 1'b0);
    run_seq("clamp15", 16'd3, 16'd4, 4'd15, OP_ADD, 0, 0, 0, 0, 1'b0);
    run_seq("hold_k5", 16'd0, 16'd1, 4'd13, OP_ADD, 0, 5, 3, 0, 1'b0);
    run_seq("rst_k8", 16'd0, 16'd1, 4'd13, OP_ADD, 0, 0, 0, 8, 1'b0);
    run_seq("after_rst", 16'd0, 16'd1, 4'd13, OP_ADD, 0, 0, 0, 0, 1'b0);
    run_seq("restart", 16'd5, 16'd11, 4'd9, OP_SUB, 0, 0, 0, 0, 1'b1);

    for (int n = 0; n < 20; n++) begin
      logic [7:0] rop;
      rop = 8'($urandom_range(3, 1));
      run_seq($sformatf("rnd%0d", n), 16'($urandom), 16'($urandom),
              4'($urandom_range(15)), rop, (n % 2 == 1) ? 30 : 0, 0, 0, 0,
              1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
